ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
EX/MEM pipeline stage directly downstream of the 16-bit execute ALU. It registers the ALU's 32-bit result, overflow flag and the instruction's control bits for the MEM stage. It splits MUL/DIV results into a low result and a HI-register write. It detects arithmetic exceptions (add/sub overflow, divide-by-zero, illegal ALU function) and runs a small exception-hold FSM, and it drives the EX-stage forwarding path.

Parameters:
DATA_W, 16, operand/result width; ALU result input is 2*DATA_W
RA_W, 4, register-file address width
PC_W, 16, program-counter width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
ex_valid  in  1  EX holds a real instruction
ex_alu_func  in  3  ALU function code of that instruction
ex_alu_out  in  2*DATA_W  ALU result
ex_of_detect  in  1  ALU overflow flag
ex_div_zero  in  1  divisor operand == 0 (from EX)
ex_rd  in  RA_W  destination register
ex_reg_write / ex_mem_read / ex_mem_write  in  1 each  control bits
ex_store_data  in  DATA_W  store operand
ex_pc  in  PC_W  instruction PC
stall_in  in  1  MEM busy; hold stage contents
flush_in  in  1  kill instruction held in stage
exc_ack  in  1  exception handler acknowledge
mem_valid  out  1  stage holds a live instruction
mem_result  out  DATA_W  low result
mem_hi_write  out  1  write HI register
mem_hi_data  out  DATA_W  HI data
mem_rd  out  RA_W; mem_reg_write, mem_mem_read, mem_mem_write  out  1 each
mem_store_data  out  DATA_W
fwd_valid  out  1; fwd_rd  out  RA_W; fwd_data  out  DATA_W  forwarding to EX
kill_younger  out  1  one-cycle pulse squashing IF/ID/EX
exc_valid  out  1; exc_pc  out  PC_W; exc_cause  out  2  exception report

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, FSM=RUN. Applies mid-stall and mid-exception.
- Priority per edge: reset > flush_in > stall_in > capture.
- Capture: when !stall_in, latch EX inputs. Latency is 1 cycle.
- stall_in=1: all registers hold. Exception detection is not evaluated.
- flush_in=1: mem_valid and all mem_* write enables clear, even while stalled. The FSM state is unaffected.
- Result split by func:
  - 000/001/010/011: mem_result = ex_alu_out[15:0]; mem_hi_write=0. Upper bits are ignored.
  - 100 (MUL): mem_result = out[15:0]; mem_hi_data = out[31:16]; mem_hi_write=1.
  - 101 (DIV): mem_result = quotient out[15:0]; mem_hi_data = remainder out[31:16]; mem_hi_write=1.
- Exceptions are checked only on a capture with ex_valid=1 and FSM=RUN. Cause codes, in priority order:
  - 11: div-zero (func 101 and ex_div_zero).
  - 01: add overflow (func 000 and of).
  - 10: sub overflow (func 001 and of).
  - 00: illegal func (110/111).
- On any exception:
  - The instruction enters as a bubble: mem_valid=0, all write enables 0.
  - exc_pc=ex_pc, exc_cause latched, exc_valid=1.
  - kill_younger pulses high for exactly that one cycle.
  - FSM goes RUN->HOLD.
- HOLD: every capture is a bubble regardless of ex_valid. exc_valid, exc_pc and exc_cause are held stable. exc_ack=1 at an edge returns the FSM to RUN and clears exc_valid on that edge; the same edge captures as a bubble. exc_ack in RUN is ignored.
- An instruction that is flushed or stalled does not raise an exception.
- Forwarding (combinational from registers):
  - fwd_valid = mem_valid & mem_reg_write & !mem_mem_read.
  - fwd_rd = mem_rd; fwd_data = mem_result.
  - fwd_valid=0 when rd=0.

Test Plan:
- Add, no overflow: func 000, out=0x0000_1234, rd=3, reg_write=1 -> next cycle mem_valid=1, mem_result=0x1234, fwd_valid=1, fwd_rd=3, mem_hi_write=0.
- MUL split: func 100, out=0x0002_0003 -> mem_result=0x0003, mem_hi_data=0x0002, mem_hi_write=1.
- DIV by zero: func 101, ex_div_zero=1, pc=0x0040 -> mem_valid=0, exc_valid=1, exc_cause=11, exc_pc=0x0040, kill_younger high one cycle. Three further valid instructions are all bubbles. exc_ack -> exc_valid=0 next edge, then the following instruction captures normally.
- Sub overflow while stalled: stall_in=1, func 001, of=1 -> no exception, contents held. Release stall -> exception cause 10 raised.
- flush_in asserted together with stall_in while stage holds valid add -> mem_valid=0, fwd_valid=0 next edge. flush during HOLD leaves exc_valid=1.
- rst_n=0 during HOLD with stall_in=1 -> all outputs 0, FSM=RUN next edge.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with MUL/DIV result split, arithmetic
// exception detection, exception-hold FSM and EX forwarding.
module ex_mem_pipe #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4,
  parameter int PC_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [2:0]          ex_alu_func,
  input  logic [2*DATA_W-1:0] ex_alu_out,
  input  logic                ex_of_detect,
  input  logic                ex_div_zero,
  input  logic [RA_W-1:0]     ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [PC_W-1:0]     ex_pc,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                exc_ack,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_result,
  output logic                mem_hi_write,
  output logic [DATA_W-1:0]   mem_hi_data,
  output logic [RA_W-1:0]     mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic [DATA_W-1:0]   mem_store_data,
  output logic                fwd_valid,
  output logic [RA_W-1:0]     fwd_rd,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                kill_younger,
  output logic                exc_valid,
  output logic [PC_W-1:0]     exc_pc,
  output logic [1:0]          exc_cause
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic valid_q, valid_d, reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic mem_write_q, mem_write_d, hi_write_q, hi_write_d, kill_q, kill_d;
  logic exc_valid_q, exc_valid_d;
  logic [DATA_W-1:0] result_q, result_d, hi_data_q, hi_data_d, store_q, store_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [PC_W-1:0] exc_pc_q, exc_pc_d;
  logic [1:0] cause_q, cause_d;
  logic muldiv, div0, add_of, sub_of, illegal, exc_hit, live;
  logic [1:0] exc_code;
  assign muldiv   = ex_alu_func[2:1] == 2'b10;
  assign div0     = ex_alu_func == 3'b101 && ex_div_zero;
  assign add_of   = ex_alu_func == 3'b000 && ex_of_detect;
  assign sub_of   = ex_alu_func == 3'b001 && ex_of_detect;
  assign illegal  = ex_alu_func[2:1] == 2'b11;
  assign exc_hit  = state_q == RUN && ex_valid && (div0 || add_of || sub_of || illegal);
  assign exc_code = div0 ? 2'b11 : add_of ? 2'b01 : sub_of ? 2'b10 : 2'b00;
  // In HOLD every capture is a bubble, as is the faulting instruction itself.
  assign live     = ex_valid && state_q == RUN && !exc_hit;
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    hi_write_d  = hi_write_q;
    result_d    = result_q;
    hi_data_d   = hi_data_q;
    store_d     = store_q;
    rd_d        = rd_q;
    exc_valid_d = exc_valid_q;
    exc_pc_d    = exc_pc_q;
    cause_d     = cause_q;
    kill_d      = 1'b0;
    if (flush_in) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      hi_write_d  = 1'b0;
    end else if (!stall_in) begin
      valid_d     = live;
      reg_write_d = live && ex_reg_write;
      mem_read_d  = live && ex_mem_read;
      mem_write_d = live && ex_mem_write;
      hi_write_d  = live && muldiv;
      result_d    = ex_alu_out[DATA_W-1:0];
      hi_data_d   = muldiv ? ex_alu_out[2*DATA_W-1:DATA_W] : '0;
      store_d     = ex_store_data;
      rd_d        = ex_rd;
      if (exc_hit) begin
        state_d     = HOLD;
        exc_valid_d = 1'b1;
        exc_pc_d    = ex_pc;
        cause_d     = exc_code;
        kill_d      = 1'b1;
      end else if (state_q == HOLD && exc_ack) begin
        state_d     = RUN;
        exc_valid_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      hi_write_q  <= 1'b0;
      result_q    <= '0;
      hi_data_q   <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
      cause_q     <= '0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      hi_write_q  <= hi_write_d;
      result_q    <= result_d;
      hi_data_q   <= hi_data_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      exc_valid_q <= exc_valid_d;
      exc_pc_q    <= exc_pc_d;
      cause_q     <= cause_d;
      kill_q      <= kill_d;
    end
  end
  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_hi_write   = hi_write_q;
  assign mem_hi_data    = hi_data_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_store_data = store_q;
  assign fwd_valid      = valid_q && reg_write_q && !mem_read_q && rd_q != '0;
  assign fwd_rd         = rd_q;
  assign fwd_data       = result_q;
  assign kill_younger   = kill_q;
  assign exc_valid      = exc_valid_q;
  assign exc_pc         = exc_pc_q;
  assign exc_cause      = cause_q;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: scoreboard bench for ex_mem_pipe; a reference model pushes the
// expected stage contents per driven cycle and they are popped after the edge.
module tb_ex_mem_pipe;
  logic clk = 1'b0, rst_n, ex_valid, ex_of_detect, ex_div_zero;
  logic ex_reg_write, ex_mem_read, ex_mem_write, stall_in, flush_in, exc_ack;
  logic [2:0] ex_alu_func;
  logic [31:0] ex_alu_out;
  logic [3:0] ex_rd, mem_rd, fwd_rd;
  logic [15:0] ex_store_data, ex_pc, mem_result, mem_hi_data, mem_store_data, fwd_data, exc_pc;
  logic mem_valid, mem_hi_write, mem_reg_write, mem_mem_read, mem_mem_write;
  logic fwd_valid, kill_younger, exc_valid;
  logic [1:0] exc_cause;
  always #5 clk = ~clk;
  ex_mem_pipe dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_func(ex_alu_func),
    .ex_alu_out(ex_alu_out), .ex_of_detect(ex_of_detect), .ex_div_zero(ex_div_zero),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .stall_in(stall_in), .flush_in(flush_in), .exc_ack(exc_ack),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_hi_write(mem_hi_write),
    .mem_hi_data(mem_hi_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .kill_younger(kill_younger), .exc_valid(exc_valid),
    .exc_pc(exc_pc), .exc_cause(exc_cause)
  );
  typedef struct packed {
    logic v, hw, rw, mr, mw, kill, ev, hold;
    logic [15:0] res, hd, sd, epc;
    logic [3:0] rd;
    logic [1:0] ec;
  } st_t;
  st_t m, sb[$];
  int vectors = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rn, st, fl, ak, v, input logic [2:0] f, input logic [31:0] o,
                     input logic of, dz, input logic [3:0] rd, input logic rw, mr, mw,
                     input logic [15:0] pc);
    st_t e;
    logic x, live, md;
    logic [1:0] c;
    @(negedge clk);
    rst_n = rn; stall_in = st; flush_in = fl; exc_ack = ak; ex_valid = v;
    ex_alu_func = f; ex_alu_out = o; ex_of_detect = of; ex_div_zero = dz; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_store_data = o[15:0] ^ 16'h5a5a;
    ex_pc = pc;
    md = f == 3'd4 || f == 3'd5;
    x = !m.hold && v && ((f == 3'd5 && dz) || (f == 3'd0 && of) || (f == 3'd1 && of) || f >= 3'd6);
    c = (f == 3'd5 && dz) ? 2'd3 : (f == 3'd0 && of) ? 2'd1 : (f == 3'd1 && of) ? 2'd2 : 2'd0;
    live = v && !x && !m.hold;
    if (!rn) m = '0;
    else if (fl) begin
      m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.hw = 0; m.kill = 0;
    end else if (st) m.kill = 0;
    else begin
      m.v = live; m.res = o[15:0]; m.hw = live && md; m.hd = md ? o[31:16] : 16'h0;
      m.rd = rd; m.rw = live && rw; m.mr = live && mr; m.mw = live && mw;
      m.sd = o[15:0] ^ 16'h5a5a; m.kill = x;
      if (x) begin
        m.ev = 1; m.epc = pc; m.ec = c; m.hold = 1;
      end else if (m.hold && ak) begin
        m.hold = 0; m.ev = 0;
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("mem_valid", 64'(mem_valid), 64'(e.v));
    check("fwd_valid", 64'(fwd_valid), 64'(e.v && e.rw && !e.mr && e.rd != 0));
    check("wr_enables", 64'({mem_reg_write, mem_mem_write, mem_hi_write}), 64'({e.rw, e.mw, e.hw}));
    check("kill_younger", 64'(kill_younger), 64'(e.kill));
    check("exc_valid", 64'(exc_valid), 64'(e.ev));
    if (e.v) begin
      check("mem_result", 64'(mem_result), 64'(e.res));
      check("mem_rd", 64'(mem_rd), 64'(e.rd));
      check("fwd_path", 64'({fwd_rd, fwd_data}), 64'({e.rd, e.res}));
      check("store_data", 64'(mem_store_data), 64'(e.sd));
      check("mem_read", 64'(mem_mem_read), 64'(e.mr));
    end
    if (e.hw) check("hi_data", 64'(mem_hi_data), 64'(e.hd));
    if (e.ev) check("exc_info", 64'({exc_pc, exc_cause}), 64'({e.epc, e.ec}));
    if (!rn) begin
      check("rst_data", {mem_result, mem_hi_data, mem_store_data, exc_pc}, 64'h0);
      check("rst_misc", 64'({mem_rd, mem_mem_read, exc_cause, fwd_valid}), 64'h0);
    end
  endtask
  task automatic add(input logic [15:0] val, input logic [3:0] rd, input logic ak);
    cyc(1, 0, 0, ak, 1, 3'd0, {16'hbeef, val}, 0, 0, rd, 1, 0, 0, 16'h0100);
  endtask
  initial begin
    m = '0;
    rst_n = 0; stall_in = 0; flush_in = 0; exc_ack = 0; ex_valid = 0; ex_alu_func = 0;
    ex_alu_out = 0; ex_of_detect = 0; ex_div_zero = 0; ex_rd = 0; ex_reg_write = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_store_data = 0; ex_pc = 0;
    repeat (2) cyc(0, 0, 0, 0, 0, 3'd0, 32'h0, 0, 0, 4'd0, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 1, 3'd0, 32'h0000_1234, 0, 0, 4'd3, 1, 0, 0, 16'h0010);
    check("tp_add_result", 64'(mem_result), 64'h1234);
    check("tp_add_fwd", 64'({fwd_valid, fwd_rd, mem_hi_write}), 64'({1'b1, 4'd3, 1'b0}));
    cyc(1, 0, 0, 0, 1, 3'd4, 32'h0002_0003, 0, 0, 4'd5, 1, 0, 0, 16'h0012);
    check("tp_mul_split", 64'({mem_result, mem_hi_data, mem_hi_write}), 64'({16'h3, 16'h2, 1'b1}));
    cyc(1, 0, 0, 0, 1, 3'd5, 32'h0001_0007, 0, 0, 4'd6, 1, 0, 0, 16'h0014);
    cyc(1, 0, 0, 0, 1, 3'd2, 32'h0000_00aa, 0, 0, 4'd7, 1, 1, 0, 16'h0016);
    cyc(1, 0, 0, 0, 1, 3'd3, 32'h0000_0055, 0, 0, 4'd0, 1, 0, 1, 16'h0018);
    cyc(1, 0, 0, 0, 0, 3'd6, 32'h0000_0001, 1, 1, 4'd2, 1, 0, 0, 16'h001a);
    cyc(1, 0, 0, 0, 1, 3'd5, 32'h1111_2222, 0, 1, 4'd4, 1, 0, 0, 16'h0040);
    check("tp_div0", 64'({mem_valid, exc_valid, exc_cause, exc_pc, kill_younger}),
          64'({1'b0, 1'b1, 2'b11, 16'h0040, 1'b1}));
    for (int i = 0; i < 3; i++) add(16'h0100 + 16'(i), 4'd1, 0);
    check("tp_hold_kill_low", 64'({kill_younger, mem_valid}), 64'h0);
    add(16'h0200, 4'd1, 1);
    check("tp_ack_clears", 64'({exc_valid, mem_valid}), 64'h0);
    add(16'h0300, 4'd2, 0);
    check("tp_after_ack", 64'({mem_valid, mem_result}), 64'({1'b1, 16'h0300}));
    add(16'h0301, 4'd2, 1);
    cyc(1, 1, 0, 0, 1, 3'd1, 32'h0000_7fff, 1, 0, 4'd9, 1, 0, 0, 16'h0050);
    cyc(1, 1, 0, 0, 1, 3'd1, 32'h0000_7fff, 1, 0, 4'd9, 1, 0, 0, 16'h0050);
    check("tp_stall_hold", 64'({exc_valid, mem_valid, mem_result}), 64'({1'b0, 1'b1, 16'h0301}));
    cyc(1, 0, 0, 0, 1, 3'd1, 32'h0000_7fff, 1, 0, 4'd9, 1, 0, 0, 16'h0050);
    check("tp_sub_of", 64'({exc_valid, exc_cause, exc_pc}), 64'({1'b1, 2'b10, 16'h0050}));
    cyc(1, 0, 1, 0, 1, 3'd0, 32'h0, 0, 0, 4'd1, 1, 0, 0, 16'h0052);
    check("tp_flush_hold", 64'(exc_valid), 64'h1);
    cyc(0, 1, 0, 0, 1, 3'd0, 32'h0, 0, 0, 4'd1, 1, 0, 0, 16'h0054);
    add(16'h0400, 4'd8, 0);
    check("tp_run_after_rst", 64'({mem_valid, fwd_valid}), 64'h3);
    cyc(1, 1, 1, 0, 1, 3'd0, 32'h0000_0500, 0, 0, 4'd8, 1, 0, 0, 16'h0056);
    check("tp_flush_stall", 64'({mem_valid, fwd_valid}), 64'h0);
    cyc(1, 0, 0, 0, 1, 3'd0, 32'h0000_8000, 1, 0, 4'd3, 1, 0, 0, 16'h0060);
    add(16'h0, 4'd3, 1);
    cyc(1, 0, 0, 0, 1, 3'd7, 32'h0000_0001, 0, 0, 4'd3, 1, 0, 0, 16'h0070);
    check("tp_illegal", 64'({exc_valid, exc_cause}), 64'({1'b1, 2'b00}));
    add(16'h0, 4'd3, 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) >= 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)),
          $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
          16'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
